// File: rtl/clock_pkg.sv
// Shared BCD types, field limits and FSM encoding for the time-of-day keeper.
// Pure declarations: no latency, no flow control.
package clock_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX = 8'h59;
    localparam bcd2_t MIN_MAX = 8'h59;
    localparam bcd2_t HR_MAX  = 8'h23;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        STOPPED    = 2'd1,
        RUNNING    = 2'd2
    } state_t;

    // Both nibbles must be decimal digits; with that, a plain compare against
    // a BCD limit orders the same way as the decimal values.
    function automatic logic bcd2_ok(bcd2_t v, bcd2_t max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX_VAL), separate units/tens digits; load beats inc.
// Updates on the clock edge after inc/load; wrap is combinational with inc, no backpressure.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX_VAL  = 8'h59,
    parameter bcd2_t INIT_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       wrap
);

    bcd_t units_q, units_d;
    bcd_t tens_q,  tens_d;
    logic at_max;

    assign at_max = ({tens_q, units_q} == MAX_VAL);
    assign wrap   = inc & at_max;
    assign value  = {tens_q, units_q};

    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (load) begin
            units_d = load_val[3:0];
            tens_d  = load_val[7:4];
        end else if (inc) begin
            if (at_max) begin
                units_d = 4'd0;
                tens_d  = 4'd0;
            end else if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            units_q <= INIT_VAL[3:0];
            tens_q  <= INIT_VAL[7:4];
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

endmodule

// File: rtl/clock_time_keeper.sv
// 24h BCD time-of-day counter advanced by rising edges of the 1 Hz divider output, with atomic load.
// Time/pulses update 2 cycles after sec_clk is sampled high; load completes in one cycle, set_ready only low after reset.
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter logic [7:0] INIT_HH = 8'h00,
    parameter logic [7:0] INIT_MM = 8'h00,
    parameter logic [7:0] INIT_SS = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sec_clk,
    input  logic       run,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       day_pulse,
    output logic       set_err
);

    logic   s1_q, s2_q;
    state_t state_q, state_d;
    logic   set_ready_q, set_ready_d;
    logic   sec_pulse_q, sec_pulse_d;
    logic   min_pulse_q, min_pulse_d;
    logic   day_pulse_q, day_pulse_d;
    logic   set_err_q,   set_err_d;

    logic tick, accept, load_ok, load_en, adv;
    logic ss_wrap, mm_wrap, hh_wrap, hh_inc;

    assign tick = s1_q & ~s2_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET_WAIT: state_d = run ? RUNNING : STOPPED;
            STOPPED:    if (run)  state_d = RUNNING;
            RUNNING:    if (!run) state_d = STOPPED;
            default:    state_d = RESET_WAIT;
        endcase
    end

    // Ready is registered off the state so it rises on the second edge after reset release.
    assign set_ready_d = (state_q != RESET_WAIT);

    assign accept  = set_valid & set_ready_q;
    assign load_ok = bcd2_ok(set_hh, HR_MAX) & bcd2_ok(set_mm, MIN_MAX) & bcd2_ok(set_ss, SEC_MAX);
    assign load_en = accept & load_ok;
    // Any accepted load, valid or not, swallows a coincident tick.
    assign adv     = tick & (state_q == RUNNING) & ~accept;
    assign hh_inc  = ss_wrap & mm_wrap;

    always_comb begin
        sec_pulse_d = adv;
        min_pulse_d = ss_wrap;
        day_pulse_d = hh_wrap;
        set_err_d   = accept & ~load_ok;
    end

    bcd_mod_counter #(.MAX_VAL(SEC_MAX), .INIT_VAL(INIT_SS)) u_sec (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (adv),
        .load     (load_en),
        .load_val (set_ss),
        .value    (ss),
        .wrap     (ss_wrap)
    );

    bcd_mod_counter #(.MAX_VAL(MIN_MAX), .INIT_VAL(INIT_MM)) u_min (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (ss_wrap),
        .load     (load_en),
        .load_val (set_mm),
        .value    (mm),
        .wrap     (mm_wrap)
    );

    bcd_mod_counter #(.MAX_VAL(HR_MAX), .INIT_VAL(INIT_HH)) u_hr (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (hh_inc),
        .load     (load_en),
        .load_val (set_hh),
        .value    (hh),
        .wrap     (hh_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= RESET_WAIT;
            set_ready_q <= 1'b0;
            sec_pulse_q <= 1'b0;
            min_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            s1_q        <= sec_clk;
            s2_q        <= s1_q;
            state_q     <= state_d;
            set_ready_q <= set_ready_d;
            sec_pulse_q <= sec_pulse_d;
            min_pulse_q <= min_pulse_d;
            day_pulse_q <= day_pulse_d;
            set_err_q   <= set_err_d;
        end
    end

    assign set_ready = set_ready_q;
    assign sec_pulse = sec_pulse_q;
    assign min_pulse = min_pulse_q;
    assign day_pulse = day_pulse_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench: seconds-of-day reference model checked every cycle, plus load table and corner sequences.
module tb_clock_time_keeper;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sec_clk = 1'b0;
    logic       run = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic       set_ready;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, min_pulse, day_pulse, set_err;

    int n_cmp = 0;
    int n_bad = 0;
    int dp_cnt = 0;
    int mp_cnt = 0;
    int sp_cnt = 0;

    // Reference model state: time as seconds since midnight.
    int m_sec;
    int m_edges;
    bit m_pend, m_last_sc, m_run, m_ready;
    bit m_sp, m_mp, m_dp, m_err;

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        bit         err;
    } load_vec_t;
    load_vec_t tbl[9];

    always #5 clk = ~clk;

    clock_time_keeper dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sec_clk   (sec_clk),
        .run       (run),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .sec_pulse (sec_pulse),
        .min_pulse (min_pulse),
        .day_pulse (day_pulse),
        .set_err   (set_err)
    );

    function automatic int bcd_val(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit field_ok(logic [7:0] v, int lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_val(v) <= lim);
    endfunction

    function automatic logic [7:0] to_bcd(int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_edges = 0;
        m_pend = 0; m_last_sc = 0; m_run = 0; m_ready = 0;
        m_sp = 0; m_mp = 0; m_dp = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit acc, tk;
        acc = set_valid && m_ready;
        tk  = m_pend && m_run;
        m_sp = 0; m_mp = 0; m_dp = 0; m_err = 0;
        if (acc) begin
            if (field_ok(set_hh, 23) && field_ok(set_mm, 59) && field_ok(set_ss, 59))
                m_sec = bcd_val(set_hh) * 3600 + bcd_val(set_mm) * 60 + bcd_val(set_ss);
            else
                m_err = 1;
        end else if (tk) begin
            m_sp  = 1;
            m_mp  = (m_sec % 60 == 59);
            m_dp  = (m_sec == 86399);
            m_sec = (m_sec + 1) % 86400;
        end
        m_pend    = sec_clk && !m_last_sc;
        m_last_sc = sec_clk;
        m_run     = run;
        m_edges++;
        m_ready   = (m_edges >= 2);
    endtask

    task automatic check_all(string tag);
        chk({tag, ".hh"}, hh, to_bcd(m_sec / 3600));
        chk({tag, ".mm"}, mm, to_bcd((m_sec / 60) % 60));
        chk({tag, ".ss"}, ss, to_bcd(m_sec % 60));
        chk({tag, ".sec_pulse"}, sec_pulse, m_sp);
        chk({tag, ".min_pulse"}, min_pulse, m_mp);
        chk({tag, ".day_pulse"}, day_pulse, m_dp);
        chk({tag, ".set_err"}, set_err, m_err);
        chk({tag, ".set_ready"}, set_ready, m_ready);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
        if (day_pulse === 1'b1) dp_cnt++;
        if (min_pulse === 1'b1) mp_cnt++;
        if (sec_pulse === 1'b1) sp_cnt++;
    endtask

    task automatic cycles(int n);
        repeat (n) step();
    endtask

    task automatic sec_edge(int hi, int lo);
        sec_clk = 1'b1;
        cycles(hi);
        sec_clk = 1'b0;
        cycles(lo);
    endtask

    task automatic do_load(logic [7:0] h, logic [7:0] m, logic [7:0] s);
        set_hh = h; set_mm = m; set_ss = s;
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        set_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all("rst");
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] eh, em, es;
        int d0, m0, s0, age;

        tbl[0] = '{8'h23, 8'h59, 8'h58, 1'b0};
        tbl[1] = '{8'h24, 8'h00, 8'h00, 1'b1};
        tbl[2] = '{8'h12, 8'h5A, 8'h00, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 8'h60, 1'b1};
        tbl[4] = '{8'h19, 8'h09, 8'h09, 1'b0};
        tbl[5] = '{8'h0A, 8'h00, 8'h00, 1'b1};
        tbl[6] = '{8'h23, 8'h59, 8'h59, 1'b0};
        tbl[7] = '{8'h20, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{8'h05, 8'h3F, 8'h00, 1'b1};

        // Count from reset: three second edges.
        run = 1'b1;
        apply_reset();
        cycles(2);
        s0 = sp_cnt;
        repeat (3) sec_edge(4, 4);
        chk("count3.ss", ss, 8'h03);
        chk("count3.pulses", sp_cnt - s0, 3);

        // Day rollover.
        do_load(8'h23, 8'h59, 8'h58);
        d0 = dp_cnt; m0 = mp_cnt;
        sec_edge(4, 4);
        chk("roll1.time", {hh, mm, ss}, 24'h235959);
        chk("roll1.day", dp_cnt - d0, 0);
        sec_edge(4, 4);
        chk("roll2.time", {hh, mm, ss}, 24'h000000);
        chk("roll2.day", dp_cnt - d0, 1);
        chk("roll2.min", mp_cnt - m0, 1);

        // Load table while stopped.
        run = 1'b0;
        cycles(2);
        eh = 8'h00; em = 8'h00; es = 8'h00;
        for (int i = 0; i < 9; i++) begin
            do_load(tbl[i].h, tbl[i].m, tbl[i].s);
            chk($sformatf("tbl%0d.err", i), set_err, tbl[i].err);
            if (!tbl[i].err) begin
                eh = tbl[i].h; em = tbl[i].m; es = tbl[i].s;
            end
            chk($sformatf("tbl%0d.time", i), {hh, mm, ss}, {eh, em, es});
            cycles(1);
        end

        // Frozen while stopped; no stale tick when run rises with sec_clk high.
        do_load(8'h01, 8'h02, 8'h03);
        repeat (5) sec_edge(3, 3);
        chk("frozen.time", {hh, mm, ss}, 24'h010203);
        sec_clk = 1'b1;
        cycles(2);
        run = 1'b1;
        cycles(6);
        chk("run_high.time", {hh, mm, ss}, 24'h010203);
        sec_clk = 1'b0;
        cycles(3);
        sec_clk = 1'b1;
        cycles(3);
        chk("run_edge.time", {hh, mm, ss}, 24'h010204);

        // Load coincident with a tick: load wins, no pulse.
        sec_clk = 1'b0;
        cycles(3);
        sec_clk = 1'b1;
        step();
        do_load(8'h10, 8'h00, 8'h00);
        chk("coinc.time", {hh, mm, ss}, 24'h100000);
        chk("coinc.sec_pulse", sec_pulse, 1'b0);
        cycles(3);
        chk("coinc.after", {hh, mm, ss}, 24'h100000);

        // Asynchronous reset mid-count.
        sec_clk = 1'b0;
        do_load(8'h12, 8'h34, 8'h56);
        cycles(3);
        repeat (2) sec_edge(3, 3);
        chk("pre_rst.time", {hh, mm, ss}, 24'h123458);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst.time", {hh, mm, ss}, 24'h000000);
        chk("async_rst.ready", set_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        step();
        chk("rel1.ready", set_ready, 1'b0);
        step();
        chk("rel2.ready", set_ready, 1'b1);

        // Randomized traffic against the model.
        age = 0;
        for (int i = 0; i < 4000; i++) begin
            if (age >= 2 && $urandom_range(0, 2) == 0) begin
                sec_clk = ~sec_clk;
                age = 0;
            end
            if ($urandom_range(0, 149) == 0) run = ~run;
            set_valid = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                set_valid = 1'b1;
                if ($urandom_range(0, 3) != 0) begin
                    set_hh = to_bcd($urandom_range(0, 23));
                    set_mm = ($urandom_range(0, 1) == 0) ? 8'h59 : to_bcd($urandom_range(0, 59));
                    set_ss = to_bcd($urandom_range(50, 59));
                end else begin
                    set_hh = 8'($urandom);
                    set_mm = 8'($urandom);
                    set_ss = 8'($urandom);
                end
            end
            step();
            age++;
        end
        set_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-of-day counter stage directly downstream of the 1 Hz frequency divider. It edge-detects the divider's square-wave output in the system clock domain. It advances a 24-hour BCD hours:minutes:seconds value once per rising edge and supports atomic time load through a valid/ready handshake. Its BCD outputs feed the seven-segment display driver.

## Interface
- `INIT_HH`, default 8'h00: BCD hours value loaded at reset (must be 00–23).
- `INIT_MM`, default 8'h00: BCD minutes value loaded at reset (must be 00–59).
- `INIT_SS`, default 8'h00: BCD seconds value loaded at reset (must be 00–59).
- `clk`  in  1: system clock (100 MHz), same clock as the divider.
- `reset_n`  in  1: reset; one clock; asynchronous, active-low.
- `sec_clk`  in  1: divider output level; one rising edge per second.
- `run`  in  1: 1 = count seconds; 0 = hold time (load still allowed).
- `set_valid`  in  1: load request; held until accepted.
- `set_ready`  out  1: block can accept a load.
- `set_hh`, `set_mm`, `set_ss`  in  8 each: BCD load value, sampled on accept.
- `hh`, `mm`, `ss`  out  8 each: current time, packed BCD (tens in [7:4], units in [3:0]).
- `sec_pulse`  out  1: 1-cycle strobe when the time advances by one second.
- `min_pulse`  out  1: 1-cycle strobe when seconds wrap 59→00.
- `day_pulse`  out  1: 1-cycle strobe when 23:59:59 → 00:00:00.
- `set_err`  out  1: 1-cycle strobe when an accepted load is rejected as invalid.

## Operation
- Edge detector: `s1 <= sec_clk`, `s2 <= s1`, and `tick = s1 & ~s2`.
  - Both `s1` and `s2` reset to 0, so a high `sec_clk` at reset release yields one tick. The divider resets low, so this does not occur in-system.
- FSM states:
  - RESET_WAIT: entered on reset; lasts one cycle; `set_ready`=0.
  - STOPPED: entered when `run`=0.
  - RUNNING: entered when `run`=1.
  - Transitions: RESET_WAIT → STOPPED or RUNNING according to `run`. STOPPED and RUNNING switch on `run` each cycle.
- `set_ready` = 1 in STOPPED and RUNNING.
- Tick in RUNNING:
  - `ss` increments in BCD and `sec_pulse` = 1.
  - `ss` 59 → 00 increments `mm` and sets `min_pulse`.
  - `mm` 59 → 00 increments `hh`.
  - `hh:mm:ss` 23:59:59 → 00:00:00 also sets `day_pulse`.
- Tick in STOPPED is discarded. The edge detector keeps tracking, so no stale tick fires when `run` rises.
- Load is accepted on `set_valid & set_ready`.
  - Valid if every nibble ≤ 9, `set_hh` ≤ 0x23, `set_mm` ≤ 0x59 and `set_ss` ≤ 0x59. A valid load replaces all three fields atomically.
  - Invalid: time is unchanged and `set_err` = 1 for one cycle.
- Load and tick in the same cycle: the load wins. The tick is dropped and no pulse is asserted. If the load is invalid, the tick is also dropped.
- Units and tens digits are kept as separate counters; binary arithmetic with decimal correction is not allowed. No digit ever holds a value above 9.
- Reset values:
  - `hh`/`mm`/`ss` = `INIT_HH`/`INIT_MM`/`INIT_SS`.
  - All pulses, `set_err` and `set_ready` = 0.
- Reset asserted mid-count: all registers return to reset values immediately, without waiting for a clock edge.

## Timing
- `sec_clk` rises before clk edge N. Then `s1`=1 after edge N, and `tick` is combinational during cycle N+1.
- `hh`/`mm`/`ss` and the pulses update at edge N+1, giving 2 cycles of latency from sampling.
- Pulses are registered and last exactly one cycle, coincident with the new time value.
- A load accepted at edge K shows the new time after edge K. `set_err` is high in cycle K+1. The handshake completes in one cycle and `set_valid` may drop right after.
- `set_ready` goes 1 at the second edge after `reset_n` deasserts.
- Minimum `sec_clk` high and low time is 2 clk cycles; shorter pulses are undefined.

## Structure
- Package `clock_pkg` holds:
  - `bcd_t` (4-bit) and `bcd2_t` (8-bit packed) types.
  - Constants `SEC_MAX`=8'h59, `MIN_MAX`=8'h59, `HR_MAX`=8'h23.
  - The FSM state enum.
- Sub-module `bcd_mod_counter`:
  - Two-digit BCD counter parameterized by max value.
  - Signals: `inc`, `load`, `load_val`, `value`, `wrap`.
  - Instantiated three times, for seconds, minutes and hours.

## Test plan
- Reset with `run`=1, then 3 `sec_clk` rising edges, each high and low for 4 cycles → `ss` = 01, 02, 03. `sec_pulse` fires 2 cycles after each edge is sampled.
- Load 23:59:58, then 2 ticks → 23:59:59, then 00:00:00. `min_pulse` and `day_pulse` are both high on the second update only.
- Load 0x24:00:00, then separately 12:5A:00 → `set_err` pulses each time and the time is unchanged.
- `run`=0 while `sec_clk` toggles 5 times → time frozen. Then `run`=1 with `sec_clk` already high → no increment until the next rising edge.
- `set_valid` coincident with a tick, loading 10:00:00 → output is exactly 10:00:00 and `sec_pulse` stays low.
- Assert `reset_n`=0 mid-count at 12:34:56 → outputs return to 00:00:00 asynchronously. `set_ready` returns to 1 at the second clk edge after release.
